// File: rtl/ram_pattern_checker.sv
// ram_pattern_checker: sweeps every address of a simple dual-port RAM read
// port once and compares each returned word with seed + addr*step, reporting
// pass/fail, a saturating mismatch count and the first failing address.
module ram_pattern_checker #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 4,
   parameter int READ_LATENCY = 1,
   parameter int COUNT_WIDTH  = 8
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic                   start_i,
   input  logic [DATA_WIDTH-1:0]  seed_i,
   input  logic [DATA_WIDTH-1:0]  step_i,
   output logic                   renable_o,
   output logic [ADDR_WIDTH-1:0]  raddr_o,
   input  logic [DATA_WIDTH-1:0]  rdata_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   pass_o,
   output logic [COUNT_WIDTH-1:0] error_count_o,
   output logic [ADDR_WIDTH-1:0]  first_error_addr_o
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_READ  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = '1;
   localparam logic [COUNT_WIDTH-1:0] COUNT_MAX  = '1;
   localparam logic [1:0]             DRAIN_LAST = 2'(READ_LATENCY - 1);

   logic [1:0]             state_q, state_d;
   logic [ADDR_WIDTH-1:0]  raddr_q, raddr_d;
   logic [DATA_WIDTH-1:0]  expected_q, expected_d;
   logic [DATA_WIDTH-1:0]  step_q, step_d;
   logic [1:0]             drain_cnt_q, drain_cnt_d;
   logic                   done_q, done_d;
   logic                   pass_q, pass_d;
   logic                   err_flag_q, err_flag_d;
   logic [COUNT_WIDTH-1:0] error_count_q, error_count_d;
   logic [ADDR_WIDTH-1:0]  first_error_addr_q, first_error_addr_d;

   logic [READ_LATENCY-1:0] valid_pipe_q;
   logic [DATA_WIDTH-1:0]   exp_pipe_q  [READ_LATENCY];
   logic [ADDR_WIDTH-1:0]   addr_pipe_q [READ_LATENCY];

   logic busy;
   logic mismatch;

   assign busy     = (state_q == ST_READ) || (state_q == ST_DRAIN);
   assign mismatch = valid_pipe_q[READ_LATENCY-1] &&
                     (rdata_i != exp_pipe_q[READ_LATENCY-1]);

   // Next-state logic: sweep sequencing, running pattern sum and statistics.
   always_comb begin
      state_d            = state_q;
      raddr_d            = raddr_q;
      expected_d         = expected_q;
      step_d             = step_q;
      drain_cnt_d        = drain_cnt_q;
      done_d             = 1'b0;
      pass_d             = pass_q;
      err_flag_d         = err_flag_q;
      error_count_d      = error_count_q;
      first_error_addr_d = first_error_addr_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               state_d            = ST_READ;
               raddr_d            = '0;
               expected_d         = seed_i;
               step_d             = step_i;
               pass_d             = 1'b0;
               err_flag_d         = 1'b0;
               error_count_d      = '0;
               first_error_addr_d = '0;
            end
         end
         ST_READ: begin
            raddr_d    = raddr_q + 1'b1;
            expected_d = expected_q + step_q;
            if (raddr_q == LAST_ADDR) begin
               state_d     = ST_DRAIN;
               drain_cnt_d = '0;
            end
         end
         ST_DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (busy && mismatch) begin
         if (error_count_q != COUNT_MAX) begin
            error_count_d = error_count_q + 1'b1;
         end
         if (!err_flag_q) begin
            err_flag_d         = 1'b1;
            first_error_addr_d = addr_pipe_q[READ_LATENCY-1];
         end
      end

      // The final compare lands on the same edge as the DRAIN->DONE step.
      if (done_d) begin
         pass_d = !err_flag_d;
      end
   end

   // State and statistics registers.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q            <= ST_IDLE;
         raddr_q            <= '0;
         expected_q         <= '0;
         step_q             <= '0;
         drain_cnt_q        <= '0;
         done_q             <= 1'b0;
         pass_q             <= 1'b0;
         err_flag_q         <= 1'b0;
         error_count_q      <= '0;
         first_error_addr_q <= '0;
      end else begin
         state_q            <= state_d;
         raddr_q            <= raddr_d;
         expected_q         <= expected_d;
         step_q             <= step_d;
         drain_cnt_q        <= drain_cnt_d;
         done_q             <= done_d;
         pass_q             <= pass_d;
         err_flag_q         <= err_flag_d;
         error_count_q      <= error_count_d;
         first_error_addr_q <= first_error_addr_d;
      end
   end

   // Delay expected value, address and valid to line up with rdata.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         valid_pipe_q <= '0;
         for (int i = 0; i < READ_LATENCY; i++) begin
            exp_pipe_q[i]  <= '0;
            addr_pipe_q[i] <= '0;
         end
      end else begin
         valid_pipe_q[0] <= (state_q == ST_READ);
         exp_pipe_q[0]   <= expected_q;
         addr_pipe_q[0]  <= raddr_q;
         for (int i = 1; i < READ_LATENCY; i++) begin
            valid_pipe_q[i] <= valid_pipe_q[i-1];
            exp_pipe_q[i]   <= exp_pipe_q[i-1];
            addr_pipe_q[i]  <= addr_pipe_q[i-1];
         end
      end
   end

   assign renable_o          = (state_q == ST_READ);
   assign raddr_o            = raddr_q;
   assign busy_o             = busy;
   assign done_o             = done_q;
   assign pass_o             = pass_q;
   assign error_count_o      = error_count_q;
   assign first_error_addr_o = first_error_addr_q;

endmodule

// File: tb/tb_ram_pattern_checker.sv
// tb_ram_pattern_checker: directed bench with three checker instances sharing
// control inputs: reg1 RAM (8-bit count), reg1 RAM (3-bit count), reg2 RAM.
module tb_ram_pattern_checker;

   logic       clock;
   logic       resetn;
   logic       start;
   logic [7:0] seed;
   logic [7:0] step;

   logic       renable_a, busy_a, done_a, pass_a;
   logic [3:0] raddr_a, fe_a;
   logic [7:0] rdata_a, ec_a;

   logic       renable_b, busy_b, done_b, pass_b;
   logic [3:0] raddr_b, fe_b;
   logic [7:0] rdata_b;
   logic [2:0] ec_b;

   logic       renable_c, busy_c, done_c, pass_c;
   logic [3:0] raddr_c, fe_c;
   logic [7:0] rdata_c, rdata_c_s1, ec_c;

   logic [7:0] mem_a [16];
   logic [7:0] mem_b [16];
   logic [7:0] mem_c [16];

   int compared;
   int mismatched;

   int busyA, doneA, busyC, doneC, seqBad;
   int startEc, startFe, startPass;

   ram_pattern_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(1), .COUNT_WIDTH(8)) dut_a (
      .clock(clock), .resetn(resetn), .start_i(start), .seed_i(seed), .step_i(step),
      .renable_o(renable_a), .raddr_o(raddr_a), .rdata_i(rdata_a), .busy_o(busy_a),
      .done_o(done_a), .pass_o(pass_a), .error_count_o(ec_a), .first_error_addr_o(fe_a));

   ram_pattern_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(1), .COUNT_WIDTH(3)) dut_b (
      .clock(clock), .resetn(resetn), .start_i(start), .seed_i(seed), .step_i(step),
      .renable_o(renable_b), .raddr_o(raddr_b), .rdata_i(rdata_b), .busy_o(busy_b),
      .done_o(done_b), .pass_o(pass_b), .error_count_o(ec_b), .first_error_addr_o(fe_b));

   ram_pattern_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(2), .COUNT_WIDTH(8)) dut_c (
      .clock(clock), .resetn(resetn), .start_i(start), .seed_i(seed), .step_i(step),
      .renable_o(renable_c), .raddr_o(raddr_c), .rdata_i(rdata_c), .busy_o(busy_c),
      .done_o(done_c), .pass_o(pass_c), .error_count_o(ec_c), .first_error_addr_o(fe_c));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single-register read port models for the latency-1 instances.
   always @(posedge clock) begin
      if (renable_a) rdata_a <= mem_a[raddr_a];
      if (renable_b) rdata_b <= mem_b[raddr_b];
   end

   // Two-register read port model for the latency-2 instance.
   always @(posedge clock) begin
      if (renable_c) rdata_c_s1 <= mem_c[raddr_c];
      rdata_c <= rdata_c_s1;
   end

   task automatic preload_a_pattern();
      for (int a = 0; a < 16; a++) mem_a[a] = 8'(3 * a);
   endtask

   // Starts a sweep and observes 40 cycles; repulseAt re-raises start at that sample index.
   task automatic run_sweep(input int repulseAt);
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      busyA = 0; doneA = 0; busyC = 0; doneC = 0; seqBad = 0;
      startEc = int'(ec_a); startFe = int'(fe_a); startPass = int'(pass_a);
      for (int i = 0; i < 40; i++) begin
         if (busy_a === 1'b1) busyA++;
         if (done_a === 1'b1) doneA++;
         if (busy_c === 1'b1) busyC++;
         if (done_c === 1'b1) doneC++;
         if (i < 16 && (raddr_a !== 4'(i) || renable_a !== 1'b1)) seqBad++;
         if (i >= 16 && (raddr_a !== 4'd0 || renable_a !== 1'b0)) seqBad++;
         start = (i == repulseAt);
         @(posedge clock); #1;
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0; start = 1'b0; seed = 8'h00; step = 8'h00;
      repeat (3) @(posedge clock);
      #1;
      compared++; if (renable_a !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_renable: got %b expected 0", renable_a); end
      compared++; if (raddr_a !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_raddr: got %0d expected 0", raddr_a); end
      compared++; if (busy_a !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_a); end
      compared++; if (done_a !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", done_a); end
      compared++; if (pass_a !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_pass: got %b expected 0", pass_a); end
      compared++; if (ec_a !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_error_count: got %0d expected 0", ec_a); end
      compared++; if (fe_a !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_first_error: got %0d expected 0", fe_a); end
      resetn = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_clean_sweep();
      preload_a_pattern();
      seed = 8'h00; step = 8'h03;
      run_sweep(-1);
      compared++; if (busyA !== 17) begin mismatched++; $display("[TB] FAIL clean_busy_cycles: got %0d expected 17", busyA); end
      compared++; if (doneA !== 1) begin mismatched++; $display("[TB] FAIL clean_done_pulses: got %0d expected 1", doneA); end
      compared++; if (seqBad !== 0) begin mismatched++; $display("[TB] FAIL clean_addr_sequence: got %0d bad cycles expected 0", seqBad); end
      compared++; if (pass_a !== 1'b1) begin mismatched++; $display("[TB] FAIL clean_pass: got %b expected 1", pass_a); end
      compared++; if (ec_a !== 8'd0) begin mismatched++; $display("[TB] FAIL clean_error_count: got %0d expected 0", ec_a); end
      compared++; if (fe_a !== 4'd0) begin mismatched++; $display("[TB] FAIL clean_first_error: got %0d expected 0", fe_a); end
   endtask

   task automatic test_corrupt();
      preload_a_pattern();
      mem_a[5] = 8'hFF; mem_a[9] = 8'hFF;
      seed = 8'h00; step = 8'h03;
      run_sweep(-1);
      compared++; if (pass_a !== 1'b0) begin mismatched++; $display("[TB] FAIL corrupt_pass: got %b expected 0", pass_a); end
      compared++; if (ec_a !== 8'd2) begin mismatched++; $display("[TB] FAIL corrupt_error_count: got %0d expected 2", ec_a); end
      compared++; if (fe_a !== 4'd5) begin mismatched++; $display("[TB] FAIL corrupt_first_error: got %0d expected 5", fe_a); end
      compared++; if (doneA !== 1) begin mismatched++; $display("[TB] FAIL corrupt_done_pulses: got %0d expected 1", doneA); end
   endtask

   task automatic test_saturate();
      for (int a = 0; a < 16; a++) mem_b[a] = 8'(3 * a) ^ 8'h80;
      seed = 8'h00; step = 8'h03;
      run_sweep(-1);
      compared++; if (ec_b !== 3'd7) begin mismatched++; $display("[TB] FAIL sat_error_count: got %0d expected 7", ec_b); end
      compared++; if (fe_b !== 4'd0) begin mismatched++; $display("[TB] FAIL sat_first_error: got %0d expected 0", fe_b); end
      compared++; if (pass_b !== 1'b0) begin mismatched++; $display("[TB] FAIL sat_pass: got %b expected 0", pass_b); end
   endtask

   task automatic test_latency2();
      for (int a = 0; a < 16; a++) mem_c[a] = 8'(8'h10 + 8'h11 * a);
      seed = 8'h10; step = 8'h11;
      run_sweep(-1);
      compared++; if (busyC !== 18) begin mismatched++; $display("[TB] FAIL lat2_busy_cycles: got %0d expected 18", busyC); end
      compared++; if (doneC !== 1) begin mismatched++; $display("[TB] FAIL lat2_done_pulses: got %0d expected 1", doneC); end
      compared++; if (pass_c !== 1'b1) begin mismatched++; $display("[TB] FAIL lat2_pass: got %b expected 1", pass_c); end
      compared++; if (ec_c !== 8'd0) begin mismatched++; $display("[TB] FAIL lat2_error_count: got %0d expected 0", ec_c); end
   endtask

   task automatic test_start_ignored();
      preload_a_pattern();
      mem_a[5] = 8'hFF;
      seed = 8'h00; step = 8'h03;
      run_sweep(4);
      compared++; if (busyA !== 17) begin mismatched++; $display("[TB] FAIL repulse_busy_cycles: got %0d expected 17", busyA); end
      compared++; if (doneA !== 1) begin mismatched++; $display("[TB] FAIL repulse_done_pulses: got %0d expected 1", doneA); end
      compared++; if (ec_a !== 8'd1) begin mismatched++; $display("[TB] FAIL repulse_error_count: got %0d expected 1", ec_a); end
      compared++; if (fe_a !== 4'd5) begin mismatched++; $display("[TB] FAIL repulse_first_error: got %0d expected 5", fe_a); end
      preload_a_pattern();
      run_sweep(-1);
      compared++; if (startEc !== 0 || startFe !== 0 || startPass !== 0) begin
         mismatched++; $display("[TB] FAIL restart_cleared: got ec=%0d fe=%0d pass=%0d expected 0/0/0", startEc, startFe, startPass);
      end
      compared++; if (pass_a !== 1'b1) begin mismatched++; $display("[TB] FAIL restart_pass: got %b expected 1", pass_a); end
      compared++; if (busyA !== 17) begin mismatched++; $display("[TB] FAIL restart_busy_cycles: got %0d expected 17", busyA); end
   endtask

   task automatic test_reset_midsweep();
      int found;
      int doneSeen;
      preload_a_pattern();
      mem_a[3] = 8'hFF;
      seed = 8'h00; step = 8'h03;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      found = 0;
      for (int i = 0; i < 40 && found == 0; i++) begin
         if (raddr_a === 4'd7) found = 1;
         else begin @(posedge clock); #1; end
      end
      compared++; if (found !== 1) begin mismatched++; $display("[TB] FAIL midreset_reach_addr7: got %0d expected 1", found); end
      compared++; if (ec_a !== 8'd1) begin mismatched++; $display("[TB] FAIL midreset_pre_error_count: got %0d expected 1", ec_a); end
      #2 resetn = 1'b0;
      #1;
      compared++; if (busy_a !== 1'b0 || renable_a !== 1'b0 || raddr_a !== 4'd0) begin
         mismatched++; $display("[TB] FAIL midreset_async: got busy=%b renable=%b raddr=%0d expected 0/0/0", busy_a, renable_a, raddr_a);
      end
      compared++; if (ec_a !== 8'd0 || fe_a !== 4'd0 || pass_a !== 1'b0) begin
         mismatched++; $display("[TB] FAIL midreset_stats: got ec=%0d fe=%0d pass=%b expected 0/0/0", ec_a, fe_a, pass_a);
      end
      doneSeen = 0;
      for (int i = 0; i < 25; i++) begin
         if (done_a === 1'b1) doneSeen++;
         if (i == 3) resetn = 1'b1;
         @(posedge clock); #1;
      end
      compared++; if (doneSeen !== 0) begin mismatched++; $display("[TB] FAIL midreset_no_done: got %0d pulses expected 0", doneSeen); end
      preload_a_pattern();
      run_sweep(-1);
      compared++; if (busyA !== 17 || doneA !== 1) begin
         mismatched++; $display("[TB] FAIL midreset_resweep: got busy=%0d done=%0d expected 17/1", busyA, doneA);
      end
      compared++; if (pass_a !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_resweep_pass: got %b expected 1", pass_a); end
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      for (int a = 0; a < 16; a++) begin
         mem_a[a] = 8'h00; mem_b[a] = 8'h00; mem_c[a] = 8'h00;
      end
      test_reset();
      test_clean_sweep();
      test_corrupt();
      test_saturate();
      test_latency2();
      test_start_ignored();
      test_reset_midsweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
